// File: rtl/stream_out.sv
// Reading end of a writer/reader port handshake that feeds a host-drained FIFO.
// A three-state handshake captures each pending value exactly once.
module stream_out #(
    parameter int DEPTH  = 39,
    parameter int DATA_W = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rready,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     read,
    input  logic                     pop,
    output logic signed [DATA_W-1:0] dout,
    output logic                     empty,
    output logic                     full,
    output logic [5:0]               count,
    output logic [5:0]               total
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [5:0]       DEPTH_CNT = 6'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, DROP} state_t;

    state_t                   state;
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic                     capture;
    logic                     take;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    assign empty   = (count == 6'd0);
    assign full    = (count == DEPTH_CNT);
    assign capture = (state == IDLE) && rready && !full;
    assign take    = pop && !empty;
    assign dout    = mem[head];

    // Storage is data only: never reset, written solely on a capture.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            read  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= 6'd0;
            total <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    read  <= capture;
                    state <= capture ? ACK : IDLE;
                end
                ACK: begin
                    read  <= 1'b0;
                    state <= DROP;
                end
                DROP: begin
                    read  <= 1'b0;
                    state <= rready ? DROP : IDLE;
                end
                default: begin
                    read  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (capture) begin
                tail  <= next_ptr(tail);
                total <= sat_inc(total);
            end
            if (take) begin
                head <= next_ptr(head);
            end

            case ({capture, take})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_out.sv
// Directed bench for stream_out: a DEPTH=4 and a DEPTH=3 instance share one
// writer/host stimulus; each scenario checks whichever instance it targets.
module tb_stream_out;

    logic               clk = 1'b0;
    logic               rst;
    logic               rready;
    logic signed [10:0] data_in;
    logic               pop;

    logic               read4, empty4, full4;
    logic signed [10:0] dout4;
    logic [5:0]         count4, total4;
    logic               read3, empty3, full3;
    logic signed [10:0] dout3;
    logic [5:0]         count3, total3;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    stream_out #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .rready(rready), .data_in(data_in), .read(read4),
        .pop(pop), .dout(dout4), .empty(empty4), .full(full4),
        .count(count4), .total(total4)
    );

    stream_out #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .rready(rready), .data_in(data_in), .read(read3),
        .pop(pop), .dout(dout3), .empty(empty3), .full(full3),
        .count(count3), .total(total3)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Writer side: hold the value until read is seen, then drop rready and
    // let the handshake return to IDLE (ACK -> DROP -> IDLE).
    task automatic push(input int v);
        int n;
        rready  = 1'b1;
        data_in = 11'(v);
        n = 0;
        do begin
            step();
            n++;
        end while (!read4 && n < 20);
        check("push_ack", int'(read4), 1);
        rready = 1'b0;
        step();
        step();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rready = 1'b0; data_in = '0; pop = 1'b0;
        #1;
        do_reset();
        check("rst_count", int'(count4), 0);
        check("rst_empty", int'(empty4), 1);
        check("rst_full",  int'(full4),  0);
        check("rst_read",  int'(read4),  0);
        check("rst_total", int'(total4), 0);

        // Single transfer of -5
        rready = 1'b1; data_in = -11'sd5;
        step();
        check("single_read", int'(read4), 1);
        check("single_count", int'(count4), 1);
        check("single_dout", int'(dout4), -5);
        check("single_total", int'(total4), 1);
        check("single_empty", int'(empty4), 0);
        step();
        check("single_ack_read", int'(read4), 0);
        step();
        check("single_drop_read", int'(read4), 0);
        check("single_drop_count", int'(count4), 1);
        rready = 1'b0;
        step();
        pop_one();
        check("single_pop_count", int'(count4), 0);
        check("single_pop_empty", int'(empty4), 1);

        // Held rready captures once
        rready = 1'b1; data_in = 11'sd7;
        repeat (10) step();
        rready = 1'b0;
        step();
        check("held_count", int'(count4), 1);
        check("held_total", int'(total4), 2);
        check("held_dout", int'(dout4), 7);
        pop_one();

        // Fill DEPTH=4 and stall
        do_reset();
        push(1); push(2); push(3); push(4);
        check("fill_full", int'(full4), 1);
        check("fill_count", int'(count4), 4);
        rready = 1'b1; data_in = 11'sd5;
        step();
        check("stall_read_a", int'(read4), 0);
        step();
        check("stall_read_b", int'(read4), 0);
        check("stall_count", int'(count4), 4);
        pop_one();
        check("stall_pop_read", int'(read4), 0);
        check("stall_pop_count", int'(count4), 3);
        step();
        check("unstall_read", int'(read4), 1);
        check("unstall_count", int'(count4), 4);
        check("unstall_dout", int'(dout4), 2);
        check("unstall_full", int'(full4), 1);
        rready = 1'b0;
        step(); step();

        // Simultaneous pop and capture at count=2
        pop_one(); pop_one();
        check("sim_pre_count", int'(count4), 2);
        check("sim_pre_dout", int'(dout4), 4);
        rready = 1'b1; data_in = 11'sd6; pop = 1'b1;
        step();
        pop = 1'b0;
        check("sim_read", int'(read4), 1);
        check("sim_count", int'(count4), 2);
        check("sim_dout", int'(dout4), 5);
        rready = 1'b0;
        step(); step();
        pop_one();
        check("sim_tail_dout", int'(dout4), 6);
        check("sim_tail_count", int'(count4), 1);

        // Wrap on DEPTH=3
        do_reset();
        push(10); push(11);
        for (int v = 12; v <= 16; v++) begin
            push(v);
            check("wrap_full", int'(full3), 1);
            check("wrap_dout", int'(dout3), v - 2);
            pop_one();
        end
        check("wrap_dout_15", int'(dout3), 15);
        pop_one();
        check("wrap_dout_16", int'(dout3), 16);
        pop_one();
        check("wrap_empty", int'(empty3), 1);
        check("wrap_total", int'(total3), 7);

        // Reset during ACK aborts, value recaptured after release
        do_reset();
        rready = 1'b1; data_in = 11'sd999;
        step();
        check("rack_read", int'(read4), 1);
        rst = 1'b1;
        step();
        check("rack_count", int'(count4), 0);
        check("rack_total", int'(total4), 0);
        check("rack_read0", int'(read4), 0);
        check("rack_empty", int'(empty4), 1);
        rst = 1'b0;
        step();
        check("rack_recap_read", int'(read4), 1);
        check("rack_recap_count", int'(count4), 1);
        check("rack_recap_dout", int'(dout4), 999);
        check("rack_recap_total", int'(total4), 1);
        rready = 1'b0;
        step(); step();

        // Pop on empty is ignored; extreme negative stored verbatim
        do_reset();
        pop_one();
        check("epop_count", int'(count4), 0);
        check("epop_empty", int'(empty4), 1);
        push(-1024);
        check("neg_dout", int'(dout4), -1024);
        check("neg_count", int'(count4), 1);
        pop_one();

        // total saturates at 63 (one capture already since reset)
        for (int i = 0; i < 62; i++) begin
            push(i);
            pop_one();
        end
        check("sat_total_63", int'(total4), 63);
        push(100);
        check("sat_total_hold", int'(total4), 63);
        check("sat_dout", int'(dout4), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
